fe_instr_queue: RTL and testbench

//  Decoupling FIFO between the front-end (fe_top) and the back-end dispatch/rename stage.
//  - Accepts one decoded_instruction_t per cycle from fe_top (valid/ready).
//  - Presents the oldest entry to dispatch (valid/yumi).
//  - Back-pressure to fe_top via ready_o, which drives fe_top.ready_i.
//  - Whole queue is discarded on a branch mispredict.
//

---
 rtl/fe_instr_queue.sv | 96 +++++++++
 tb/tb_fe_instr_queue.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fe_instr_queue.sv
// fe_instr_queue: decoupling FIFO between fe_top and dispatch/rename.
// Writes use valid/ready. The head entry is consumed with valid/yumi.
// A mispredict flush empties the whole queue.
// Optional feature: define FE_IQ_BYPASS_EN to let an instruction arriving at an
// empty queue reach data_o in the same cycle.
module fe_instr_queue #(
   parameter int unsigned WIDTH_P = 32,
   parameter int unsigned DEPTH_P = 8
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       flush_i,
   input  logic                       valid_i,
   input  logic [WIDTH_P-1:0]         data_i,
   output logic                       ready_o,
   output logic                       valid_o,
   output logic [WIDTH_P-1:0]         data_o,
   input  logic                       yumi_i,
   output logic [$clog2(DEPTH_P):0]   count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH_P);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH_P-1:0] r_mem [DEPTH_P];
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [CNT_W-1:0]   r_count;
   logic               r_ready;
   logic               r_valid;

   logic               w_bypass;
   logic               w_enq;
   logic               w_deq;
   logic [PTR_W-1:0]   w_rd_ptr_next;
   logic [PTR_W-1:0]   w_wr_ptr_next;
   logic [CNT_W-1:0]   w_count_next;

   // Head presentation, handshake qualification and next-state pointer/count math.
   always_comb begin
      w_bypass      = 1'b0;
`ifdef FE_IQ_BYPASS_EN
      w_bypass      = (r_count == '0) && r_ready && valid_i && !flush_i;
`endif
      valid_o       = r_valid | w_bypass;
      data_o        = w_bypass ? data_i : r_mem[r_rd_ptr];
      w_enq         = valid_i & r_ready & ~flush_i;
      w_deq         = yumi_i & valid_o & ~flush_i;
      // A bypassed entry consumed in its arrival cycle never touches storage.
      if (w_bypass && yumi_i) begin
         w_enq = 1'b0;
         w_deq = 1'b0;
      end
      w_rd_ptr_next = r_rd_ptr + PTR_W'(w_deq);
      w_wr_ptr_next = r_wr_ptr + PTR_W'(w_enq);
      w_count_next  = r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
      if (flush_i) begin
         w_rd_ptr_next = '0;
         w_wr_ptr_next = '0;
         w_count_next  = '0;
      end
   end

   // Pointer/count state; ready and valid are precomputed from next count so they are pure flops.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_ready  <= 1'b0;
         r_valid  <= 1'b0;
      end else begin
         r_rd_ptr <= w_rd_ptr_next;
         r_wr_ptr <= w_wr_ptr_next;
         r_count  <= w_count_next;
         r_ready  <= (w_count_next != CNT_W'(DEPTH_P));
         r_valid  <= (w_count_next != '0);
      end
   end

   // Entry storage; contents deliberately survive reset.
   always_ff @(posedge clk_i) begin
      if (w_enq) begin
         r_mem[r_wr_ptr] <= data_i;
      end
   end

   assign ready_o = r_ready;
   assign count_o = r_count;

   // Dispatch must never consume from an empty queue.
   a_no_yumi_when_empty : assert property (@(posedge clk_i) disable iff (!reset_i)
      !(yumi_i && !valid_o))
      else $error("yumi_i asserted while valid_o is low");

endmodule

// File: tb/tb_fe_instr_queue.sv
// Directed bench for fe_instr_queue: the driver pushes expected head data into a
// scoreboard queue and a separate monitor pops and compares on each consume.
module tb_fe_instr_queue;

   localparam int unsigned W = 32;
   localparam int unsigned D = 8;

   logic             clk_i = 1'b0;
   logic             reset_i;
   logic             flush_i;
   logic             valid_i;
   logic [W-1:0]     data_i;
   logic             ready_o;
   logic             valid_o;
   logic [W-1:0]     data_o;
   logic             yumi_i;
   logic [3:0]       count_o;

   int total = 0;
   int bad   = 0;
   logic [W-1:0] exp_q [$];

   fe_instr_queue #(.WIDTH_P(W), .DEPTH_P(D)) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .flush_i (flush_i),
      .valid_i (valid_i),
      .data_i  (data_i),
      .ready_o (ready_o),
      .valid_o (valid_o),
      .data_o  (data_o),
      .yumi_i  (yumi_i),
      .count_o (count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp_v, $time);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      valid_i = 1'b0;
      yumi_i  = 1'b0;
      flush_i = 1'b0;
      data_i  = '0;
   endtask

   // Enqueue a value and record it as the next expected head.
   task automatic enq(input logic [W-1:0] v);
      valid_i = 1'b1;
      data_i  = v;
      exp_q.push_back(v);
      step();
      valid_i = 1'b0;
   endtask

   task automatic drain(input int n);
      yumi_i = 1'b1;
      for (int k = 0; k < n; k++) step();
      yumi_i = 1'b0;
   endtask

   // Monitor: every accepted consume is checked against the scoreboard head.
   always @(negedge clk_i) begin
      if (reset_i && valid_o && yumi_i && !flush_i) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL head_data: got 0x%0h expected nothing (scoreboard empty)", data_o);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            if (data_o !== e) begin
               bad++;
               $display("FAIL head_data: got 0x%0h expected 0x%0h at %0t", data_o, e, $time);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time bound");
      $fatal(1, "timeout");
   end

   initial begin
      reset_i = 1'b0;
      idle();
      // Reset held for three cycles.
      for (int k = 0; k < 3; k++) step();
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_ready", 32'(ready_o), 32'd0);
      chk("rst_count", 32'(count_o), 32'd0);
      reset_i = 1'b1;
      step();
      chk("post_rst_ready", 32'(ready_o), 32'd1);
      chk("post_rst_count", 32'(count_o), 32'd0);
      chk("post_rst_valid", 32'(valid_o), 32'd0);

      // Fill to full, drop a 9th, then drain in order.
      for (int k = 1; k <= 8; k++) enq(W'(32'hA0 + k));
      chk("full_count", 32'(count_o), 32'd8);
      chk("full_ready", 32'(ready_o), 32'd0);
      valid_i = 1'b1;
      data_i  = 32'hEE;
      step();
      valid_i = 1'b0;
      chk("drop_count", 32'(count_o), 32'd8);
      drain(8);
      chk("drained_valid", 32'(valid_o), 32'd0);
      chk("drained_count", 32'(count_o), 32'd0);

      // Steady-state occupancy 3 with simultaneous enq/deq across pointer wrap.
      for (int k = 1; k <= 3; k++) enq(W'(32'hB0 + k));
      valid_i = 1'b1;
      yumi_i  = 1'b1;
      for (int k = 0; k < 20; k++) begin
         data_i = W'(32'hC0 + k);
         exp_q.push_back(data_i);
         step();
         if (k == 9) chk("steady_count_mid", 32'(count_o), 32'd3);
      end
      valid_i = 1'b0;
      yumi_i  = 1'b0;
      chk("steady_count", 32'(count_o), 32'd3);
      drain(3);
      chk("steady_drained", 32'(count_o), 32'd0);

      // Flush at count 5 with concurrent enq and deq.
      for (int k = 1; k <= 5; k++) enq(W'(32'hD0 + k));
      flush_i = 1'b1;
      valid_i = 1'b1;
      yumi_i  = 1'b1;
      data_i  = 32'hDF;
      #1;
      chk("flush_cycle_count", 32'(count_o), 32'd5);
      chk("flush_cycle_valid", 32'(valid_o), 32'd1);
      step();
      exp_q.delete();
      idle();
      chk("post_flush_count", 32'(count_o), 32'd0);
      chk("post_flush_valid", 32'(valid_o), 32'd0);
      chk("post_flush_ready", 32'(ready_o), 32'd1);
      enq(32'hE1);
      drain(1);

      // Full queue with yumi and valid together: enqueue refused.
      for (int k = 1; k <= 8; k++) enq(W'(32'hF0 + k));
      valid_i = 1'b1;
      yumi_i  = 1'b1;
      data_i  = 32'hFE;
      #1;
      chk("full_deq_ready", 32'(ready_o), 32'd0);
      step();
      idle();
      chk("full_deq_count", 32'(count_o), 32'd7);
      chk("full_deq_ready_next", 32'(ready_o), 32'd1);
      drain(7);
      chk("full_deq_drained", 32'(count_o), 32'd0);

      // Empty-queue arrival latency.
`ifdef FE_IQ_BYPASS_EN
      valid_i = 1'b1;
      yumi_i  = 1'b1;
      data_i  = 32'h55;
      exp_q.push_back(32'h55);
      #1;
      chk("bypass_valid", 32'(valid_o), 32'd1);
      chk("bypass_data", data_o, 32'h55);
      step();
      idle();
      chk("bypass_count", 32'(count_o), 32'd0);
      chk("bypass_valid_after", 32'(valid_o), 32'd0);
`else
      valid_i = 1'b1;
      data_i  = 32'h55;
      exp_q.push_back(32'h55);
      #1;
      chk("nobypass_valid_same", 32'(valid_o), 32'd0);
      step();
      idle();
      chk("nobypass_valid_next", 32'(valid_o), 32'd1);
      chk("nobypass_count", 32'(count_o), 32'd1);
      chk("nobypass_data", data_o, 32'h55);
      drain(1);
`endif

      step();
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
